// File: rtl/fp_add_pipe.sv
// Three-stage floating-point adder/subtractor: align, add, normalise/round/pack.
// Latency 3 cycles at 1 beat/cycle; every stage holds together while the output is stalled.
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         CLK,
  input  logic         RESETn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Sum,
  output logic         ovf,
  output logic         unf,
  output logic         inv
);

  localparam int SW  = MAN_W + 4;
  localparam int RW  = MAN_W + 2;
  localparam int LZW = $clog2(SW + 1);
  localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] ma, mb;
  logic [W-2:0]     mag_a, mag_b, mag_x, mag_y;
  logic             swap, sx, sy;
  logic [SW-1:0]    x_ext, y_ext, y_shr, y_al;
  logic             spec, spec_inv;
  logic [W-1:0]     spec_dat;

  always_comb begin
    sa     = A[W-1];
    sb     = B[W-1] ^ sub;
    ea     = A[W-2:MAN_W];
    eb     = B[W-2:MAN_W];
    ma     = A[MAN_W-1:0];
    mb     = B[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EMAX) && (ma == '0);
    b_inf  = (eb == EMAX) && (mb == '0);
    a_nan  = (ea == EMAX) && (ma != '0);
    b_nan  = (eb == EMAX) && (mb != '0);
    // subnormals compare as zero so they can never become X
    mag_a  = {ea, ma & {MAN_W{~a_zero}}};
    mag_b  = {eb, mb & {MAN_W{~b_zero}}};
    swap   = mag_b > mag_a;
    sx     = swap ? sb : sa;
    sy     = swap ? sa : sb;
    mag_x  = swap ? mag_b : mag_a;
    mag_y  = swap ? mag_a : mag_b;
    ex     = mag_x[W-2:MAN_W];
    ey     = mag_y[W-2:MAN_W];
    d      = ex - ey;
    x_ext  = {1'b1, mag_x[MAN_W-1:0], 3'b000};
    y_ext  = {(ey != '0), mag_y[MAN_W-1:0], 3'b000};
    y_shr  = y_ext >> d;
    if (32'(d) >= MAN_W + 3)
      y_al = {{(SW-1){1'b0}}, |y_ext};
    else
      y_al = y_shr | {{(SW-1){1'b0}}, ((y_shr << d) != y_ext)};

    spec     = 1'b1;
    spec_inv = 1'b0;
    spec_dat = '0;
    if (a_nan || b_nan)
      spec_dat = QNAN;
    else if (a_inf && b_inf && (sa != sb)) begin
      spec_dat = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf)
      spec_dat = {sa, EMAX, {MAN_W{1'b0}}};
    else if (b_inf)
      spec_dat = {sb, EMAX, {MAN_W{1'b0}}};
    else if (a_zero && b_zero)
      spec_dat = {sa & sb, {(W-1){1'b0}}};
    else
      spec = 1'b0;
  end

  logic             s1_vld, s1_spec, s1_inv, s1_sgn, s1_sub;
  logic [W-1:0]     s1_dat;
  logic [EXP_W-1:0] s1_ex;
  logic [SW-1:0]    s1_mx, s1_my;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_vld <= 1'b0; s1_spec <= 1'b0; s1_inv <= 1'b0; s1_sgn <= 1'b0; s1_sub <= 1'b0;
      s1_dat <= '0;   s1_ex   <= '0;   s1_mx  <= '0;   s1_my  <= '0;
    end else if (en) begin
      s1_vld <= in_valid; s1_spec <= spec;  s1_inv <= spec_inv; s1_sgn <= sx; s1_sub <= sx ^ sy;
      s1_dat <= spec_dat; s1_ex   <= ex;    s1_mx  <= x_ext;    s1_my  <= y_al;
    end
  end

  logic [SW:0] sum_d;
  assign sum_d = s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});

  logic             s2_vld, s2_spec, s2_inv, s2_sgn;
  logic [W-1:0]     s2_dat;
  logic [EXP_W-1:0] s2_ex;
  logic [SW:0]      s2_sum;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s2_vld <= 1'b0; s2_spec <= 1'b0; s2_inv <= 1'b0; s2_sgn <= 1'b0;
      s2_dat <= '0;   s2_ex   <= '0;   s2_sum <= '0;
    end else if (en) begin
      s2_vld <= s1_vld; s2_spec <= s1_spec; s2_inv <= s1_inv; s2_sgn <= s1_sgn;
      s2_dat <= s1_dat; s2_ex   <= s1_ex;   s2_sum <= sum_d;
    end
  end

  logic [LZW-1:0] lz;
  logic [SW-1:0]  nm;
  logic [EW-1:0]  ne, ne_r;
  logic [RW-1:0]  rm;
  logic           rup, r_ovf, r_unf;
  logic [W-1:0]   res;

  always_comb begin
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (s2_sum[i]) lz = LZW'(SW - 1 - i);
    if (s2_sum[SW]) begin
      nm = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      ne = EW'(s2_ex) + EW'(1);
    end else begin
      nm = s2_sum[SW-1:0] << lz;
      ne = EW'(s2_ex) - EW'(lz);
    end
    rup  = nm[2] & (nm[3] | nm[1] | nm[0]);
    rm   = {1'b0, nm[SW-1:3]} + RW'(rup);
    // a carry out of rounding leaves an all-zero fraction one binade up
    ne_r = ne + EW'(rm[RW-1]);
    res  = {s2_sgn, ne_r[EXP_W-1:0], rm[RW-1] ? {MAN_W{1'b0}} : rm[MAN_W-1:0]};
    r_ovf = 1'b0;
    r_unf = 1'b0;
    if (s2_spec)
      res = s2_dat;
    else if (s2_sum == '0)
      res = '0;
    else if ($signed(ne_r) >= $signed(EW'(EMAX))) begin
      res   = {s2_sgn, EMAX, {MAN_W{1'b0}}};
      r_ovf = 1'b1;
    end else if ($signed(ne_r) <= $signed(EW'(0))) begin
      res   = {s2_sgn, {(W-1){1'b0}}};
      r_unf = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid <= 1'b0; Sum <= '0; ovf <= 1'b0; unf <= 1'b0; inv <= 1'b0;
    end else if (en) begin
      out_valid <= s2_vld;
      Sum       <= res;
      ovf       <= s2_vld & r_ovf;
      unf       <= s2_vld & r_unf;
      inv       <= s2_vld & s2_spec & s2_inv;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: half-precision vectors, backpressure, mid-flight reset,
// plus a single-precision instance.
module tb_fp_add_pipe;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        in_valid, in_ready, sub, out_valid, out_ready, ovf, unf, inv;
  logic [15:0] A, B, Sum;

  logic        v32_in_valid, v32_in_ready, v32_sub, v32_out_valid, v32_out_ready;
  logic        v32_ovf, v32_unf, v32_inv;
  logic [31:0] v32_a, v32_b, v32_sum;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fp_add_pipe dut (
    .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .ovf(ovf), .unf(unf), .inv(inv)
  );

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .CLK(CLK), .RESETn(RESETn), .in_valid(v32_in_valid), .in_ready(v32_in_ready),
    .A(v32_a), .B(v32_b), .sub(v32_sub), .out_valid(v32_out_valid), .out_ready(v32_out_ready),
    .Sum(v32_sum), .ovf(v32_ovf), .unf(v32_unf), .inv(v32_inv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one beat through an otherwise idle pipe; flags are {ovf, unf, inv}
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] exp_sum, input logic [2:0] exp_flg);
    int lat;
    @(negedge CLK);
    A = a; B = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_sum"}, Sum, exp_sum);
    chk({tag, "_flg"}, {ovf, unf, inv}, exp_flg);
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_sum);
    int lat;
    @(negedge CLK);
    v32_a = a; v32_b = b; v32_sub = 1'b0; v32_in_valid = 1'b1;
    @(negedge CLK);
    v32_in_valid = 1'b0;
    lat = 1;
    while (!v32_out_valid && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_sum"}, v32_sum, exp_sum);
    chk({tag, "_flg"}, {v32_ovf, v32_unf, v32_inv}, 0);
  endtask

  logic [15:0] bp_a [6];
  logic [15:0] bp_e [5];

  initial begin
    int fi, got, stale;
    in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; out_ready = 1'b1;
    v32_in_valid = 1'b0; v32_a = '0; v32_b = '0; v32_sub = 1'b0; v32_out_ready = 1'b1;
    RESETn = 1'b0;
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_flg", {ovf, unf, inv}, 0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;

    run_one("add_1p1",   16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000);
    run_one("sub_3m1",   16'h4200, 16'h3C00, 1'b1, 16'h4000, 3'b000);
    run_one("lzc",       16'h3C01, 16'h3C00, 1'b1, 16'h1400, 3'b000);
    run_one("cancel",    16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000);
    run_one("neg_res",   16'h3C00, 16'h4200, 1'b1, 16'hC000, 3'b000);
    run_one("rne_tie",   16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b000);
    run_one("rne_up",    16'h3C00, 16'h1600, 1'b0, 16'h3C02, 3'b000);
    run_one("sticky",    16'h3C00, 16'h0400, 1'b0, 16'h3C00, 3'b000);
    run_one("ovf",       16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100);
    run_one("inf_inf",   16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b001);
    run_one("inf_fin",   16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000);
    run_one("sub_inf",   16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000);
    run_one("nan_in",    16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 3'b000);
    run_one("unf",       16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b010);
    run_one("neg_zeros", 16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000);
    run_one("opp_ones",  16'hBC00, 16'h3C00, 1'b0, 16'h0000, 3'b000);

    // backpressure: 1+1, 2+1, 3+1, 4+1, 5+1 with the output stalled for a while
    bp_a[0] = 16'h3C00; bp_a[1] = 16'h4000; bp_a[2] = 16'h4200;
    bp_a[3] = 16'h4400; bp_a[4] = 16'h4500; bp_a[5] = 16'h0000;
    bp_e[0] = 16'h4000; bp_e[1] = 16'h4200; bp_e[2] = 16'h4400;
    bp_e[3] = 16'h4500; bp_e[4] = 16'h4600;
    fi = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge CLK);
      out_ready = (cyc >= 8);
      in_valid  = (fi < 5);
      A = bp_a[fi]; B = 16'h3C00; sub = 1'b0;
      #1;
      if (cyc >= 4 && cyc < 8) begin
        chk("bp_stall_vld", out_valid, 1);
        chk("bp_stall_rdy", in_ready, 0);
        chk("bp_stall_sum", Sum, 16'h4000);
      end
      if (out_valid && out_ready) begin
        chk("bp_order", Sum, bp_e[got]);
        got++;
      end
      if (in_valid && in_ready) fi++;
    end
    in_valid = 1'b0;
    chk("bp_count", got, 5);
    @(negedge CLK);
    #1;
    chk("bp_drain", out_valid, 0);

    // reset with one result at the output and two beats behind it
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      A = 16'h3C00; B = 16'h3C00; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    chk("rst_pre_vld", out_valid, 1);
    RESETn = 1'b0;
    #1;
    chk("rst_async_vld", out_valid, 0);
    chk("rst_async_sum", Sum, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge CLK);
      if (out_valid) stale++;
    end
    chk("rst_stale", stale, 0);
    run_one("post_rst", 16'h4200, 16'h3C00, 1'b0, 16'h4400, 3'b000);

    run32("sp_1p1", 32'h3F800000, 32'h3F800000, 32'h40000000);
    run32("sp_tie", 32'h3F800000, 32'h33800000, 32'h3F800000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
